// File: rtl/fifo_rd_ctrl.sv
// Read-side controller of an asynchronous FIFO: Gray read pointer, empty flag and a registered output stage.
// Define FIFO_RD_LEVEL_EN to add the registered rd_level occupancy output.
module fifo_rd_ctrl #(
  parameter int ADD_WIDTH  = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                  R_CLK,
  input  logic                  R_RST,
  input  logic [ADD_WIDTH-1:0]  rq2_wptr,
  input  logic [DATA_WIDTH-1:0] rdata_mem,
  input  logic                  rd_ready,
  output logic [ADD_WIDTH-2:0]  raddr,
  output logic [ADD_WIDTH-1:0]  rptr,
  output logic                  rempty,
  output logic                  rd_valid,
  output logic [DATA_WIDTH-1:0] rd_data
`ifdef FIFO_RD_LEVEL_EN
  ,
  output logic [ADD_WIDTH-1:0]  rd_level
`endif
);

  logic [ADD_WIDTH-1:0] rbin;
  logic                 adv;

  assign raddr  = rbin[ADD_WIDTH-2:0];
  assign rptr   = rbin ^ (rbin >> 1);
  assign rempty = (rptr == rq2_wptr);

  // The output register takes a new word whenever it is empty or being drained.
  assign adv = !rempty && (!rd_valid || rd_ready);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge R_CLK) begin
    if (R_RST) begin
      rbin     <= '0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (adv) begin
      rbin     <= rbin + 1'b1;
      rd_valid <= 1'b1;
      rd_data  <= rdata_mem;
    end else if (rd_valid && rd_ready) begin
      rd_valid <= 1'b0;
    end
  end

`ifdef FIFO_RD_LEVEL_EN
  logic [ADD_WIDTH-1:0] wbin;

  always_comb begin
    wbin = rq2_wptr;
    for (int i = ADD_WIDTH - 2; i >= 0; i--) begin
      wbin[i] = wbin[i+1] ^ rq2_wptr[i];
    end
  end

  always_ff @(posedge R_CLK) begin
    if (R_RST) rd_level <= '0;
    else       rd_level <= wbin - rbin;
  end
`endif

endmodule

// File: tb/tb_fifo_rd_ctrl.sv
// Directed bench for fifo_rd_ctrl: a small memory array plus a hand-driven Gray write pointer.
module tb_fifo_rd_ctrl;

  logic       R_CLK = 1'b0;
  logic       R_RST;
  logic [3:0] rq2_wptr;
  logic [7:0] rdata_mem;
  logic       rd_ready;
  logic [2:0] raddr;
  logic [3:0] rptr;
  logic       rempty;
  logic       rd_valid;
  logic [7:0] rd_data;
`ifdef FIFO_RD_LEVEL_EN
  logic [3:0] rd_level;
`endif

  logic [7:0] mem [8];
  logic [3:0] wbin;
  int checks = 0;
  int passed = 0;

  always #5 R_CLK = ~R_CLK;

  assign rdata_mem = mem[raddr];

  fifo_rd_ctrl #(.ADD_WIDTH(4), .DATA_WIDTH(8)) dut (
    .R_CLK     (R_CLK),
    .R_RST     (R_RST),
    .rq2_wptr  (rq2_wptr),
    .rdata_mem (rdata_mem),
    .rd_ready  (rd_ready),
    .raddr     (raddr),
    .rptr      (rptr),
    .rempty    (rempty),
    .rd_valid  (rd_valid),
    .rd_data   (rd_data)
`ifdef FIFO_RD_LEVEL_EN
    ,
    .rd_level  (rd_level)
`endif
  );

  function automatic logic [3:0] gray(input logic [3:0] b);
    return b ^ (b >> 1);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge R_CLK);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 8; i++) mem[i] = 8'h00;
    R_RST    = 1'b1;
    rq2_wptr = 4'b0000;
    rd_ready = 1'b1;
    tick();
    tick();
    R_RST = 1'b0;
    check("reset_rd_data", 32'(rd_data), 32'h00);

    // Idle empty FIFO stays empty.
    for (int c = 0; c < 10; c++) begin
      tick();
      check("idle_rempty",   32'(rempty),   32'd1);
      check("idle_rd_valid", 32'(rd_valid), 32'd0);
      check("idle_raddr",    32'(raddr),    32'd0);
      check("idle_rptr",     32'(rptr),     32'd0);
    end

    // Single word.
    mem[0]   = 8'hA5;
    rq2_wptr = 4'b0001;
    #1;
    check("one_rempty_fall", 32'(rempty), 32'd0);
    tick();
    check("one_rd_valid", 32'(rd_valid), 32'd1);
    check("one_rd_data",  32'(rd_data),  32'hA5);
    check("one_rptr",     32'(rptr),     32'b0001);
    tick();
    check("one_drained_valid",  32'(rd_valid), 32'd0);
    check("one_drained_rempty", 32'(rempty),   32'd1);
    check("one_data_hold",      32'(rd_data),  32'hA5);

    // Full burst of 8 words from a fresh reset.
    R_RST    = 1'b1;
    rq2_wptr = 4'b0000;
    tick();
    R_RST = 1'b0;
    check("rst2_rptr", 32'(rptr), 32'd0);
    for (int i = 0; i < 8; i++) mem[i] = 8'h10 + 8'(i);
    rq2_wptr = 4'b1100;
    for (int i = 0; i < 8; i++) begin
      tick();
      check("burst_valid", 32'(rd_valid), 32'd1);
      check("burst_data",  32'(rd_data),  32'h10 + 32'(i));
    end
    check("burst_rptr",   32'(rptr),   32'b1100);
    check("burst_raddr",  32'(raddr),  32'd0);
    check("burst_rempty", 32'(rempty), 32'd1);
    tick();
    check("burst_end_valid", 32'(rd_valid), 32'd0);

    // Backpressure with 3 words available (rbin 8 -> 11).
    mem[0]   = 8'hC0;
    mem[1]   = 8'hC1;
    mem[2]   = 8'hC2;
    rd_ready = 1'b0;
    rq2_wptr = gray(4'd11);
    for (int c = 0; c < 4; c++) begin
      tick();
      check("stall_valid", 32'(rd_valid), 32'd1);
      check("stall_data",  32'(rd_data),  32'hC0);
      check("stall_raddr", 32'(raddr),    32'd1);
    end
    rd_ready = 1'b1;
    tick();
    check("release_data1", 32'(rd_data), 32'hC1);
    tick();
    check("release_data2",  32'(rd_data),  32'hC2);
    check("release_valid2", 32'(rd_valid), 32'd1);
    check("release_rempty", 32'(rempty),   32'd1);
    tick();
    check("release_end_valid", 32'(rd_valid), 32'd0);

    // 20 interleaved words across the pointer wrap (rbin 11 -> 31 mod 16).
    wbin = 4'd11;
    for (int k = 0; k < 20; k++) begin
      mem[wbin[2:0]] = 8'h40 + 8'(k);
      wbin           = wbin + 4'd1;
      rq2_wptr       = gray(wbin);
      tick();
      check("stream_valid", 32'(rd_valid), 32'd1);
      check("stream_data",  32'(rd_data),  32'h40 + 32'(k));
      if (wbin == 4'd15) check("wrap_rptr_pre",  32'(rptr), 32'b1000);
      if (wbin == 4'd0)  check("wrap_rptr_zero", 32'(rptr), 32'b0000);
    end
    check("stream_end_raddr", 32'(raddr), 32'd7);

    // Reset while a word is held and 4 more are pending.
    rd_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      mem[wbin[2:0]] = 8'h60 + 8'(k);
      wbin           = wbin + 4'd1;
    end
    rq2_wptr = gray(wbin);
    tick();
    check("pre_rst_valid", 32'(rd_valid), 32'd1);
    check("pre_rst_data",  32'(rd_data),  32'h53);
    R_RST = 1'b1;
    tick();
    check("rst_valid", 32'(rd_valid), 32'd0);
    check("rst_rptr",  32'(rptr),     32'd0);
    check("rst_raddr", 32'(raddr),    32'd0);
    check("rst_data",  32'(rd_data),  32'h00);
`ifdef FIFO_RD_LEVEL_EN
    check("rst_level", 32'(rd_level), 32'd0);
`endif
    R_RST    = 1'b0;
    mem[0]   = 8'h77;
    rq2_wptr = 4'b0110;
    tick();
    check("post_rst_valid", 32'(rd_valid), 32'd1);
    check("post_rst_data",  32'(rd_data),  32'h77);
    check("post_rst_raddr", 32'(raddr),    32'd1);
`ifdef FIFO_RD_LEVEL_EN
    check("level_4", 32'(rd_level), 32'b0100);
    tick();
    check("level_3", 32'(rd_level), 32'b0011);
`endif

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
